scr1_dmem_resp_sram: RTL



---
 rtl/scr1_dmem_resp_sram.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/scr1_dmem_resp_sram.sv
// DMEM-side responder: word-organised SRAM that serves one request at a time
// and answers after a fixed, parameterised latency.
module scr1_dmem_resp_sram #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req_i,
    input  logic        dmem_cmd_i,
    input  logic [1:0]  dmem_width_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic        dmem_hold_i,
    output logic        dmem_req_ack_o,
    output logic [31:0] dmem_rdata_o,
    output logic [1:0]  dmem_resp_o
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        cmd_q;
    logic        err_q;
    logic [1:0]  width_q;
    logic [1:0]  alo_q;
    logic [31:0] word_q;
    logic [31:0] mem_q [0:MEM_WORDS-1];

    logic [31:0]      offset;
    logic             in_range;
    logic             req_err;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wdata_rep;
    logic [31:0]      shifted;

    assign offset   = dmem_addr_i - BASE_ADDR;
    assign in_range = (dmem_addr_i >= BASE_ADDR) && ({1'b0, offset} < MEM_BYTES);
    assign idx      = offset[IDX_W+1:2];

    always_comb begin
        req_err = ~in_range;
        case (dmem_width_i)
            2'd1:    req_err = req_err | dmem_addr_i[0];
            2'd2:    req_err = req_err | (dmem_addr_i[1:0] != 2'b00);
            2'd3:    req_err = 1'b1;
            default: ;
        endcase
    end

    assign dmem_req_ack_o = (state_q == IDLE) & ~dmem_hold_i & ~rst;
    assign accept         = dmem_req_i & dmem_req_ack_o;

    // Replicate store data across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = dmem_wdata_i;
        case (dmem_width_i)
            2'd0: begin
                be        = 4'b0001 << dmem_addr_i[1:0];
                wdata_rep = {4{dmem_wdata_i[7:0]}};
            end
            2'd1: begin
                be        = dmem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{dmem_wdata_i[15:0]}};
            end
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Array and read register carry no reset so the array maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (dmem_cmd_i && !req_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
            word_q <= mem_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= 1'b0;
            err_q   <= 1'b0;
            width_q <= 2'd0;
            alo_q   <= 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cmd_q   <= dmem_cmd_i;
                        err_q   <= req_err;
                        width_q <= dmem_width_i;
                        alo_q   <= dmem_addr_i[1:0];
                        if (LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign shifted = word_q >> {alo_q, 3'b000};

    always_comb begin
        dmem_resp_o  = 2'd0;
        dmem_rdata_o = 32'd0;
        if (state_q == RESP) begin
            dmem_resp_o = err_q ? 2'd2 : 2'd1;
            if (!err_q && !cmd_q) begin
                case (width_q)
                    2'd0:    dmem_rdata_o = {24'd0, shifted[7:0]};
                    2'd1:    dmem_rdata_o = {16'd0, shifted[15:0]};
                    default: dmem_rdata_o = shifted;
                endcase
            end
        end
    end

endmodule
